// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand, control and status bundle for alu_muldiv
interface alu_muldiv_if;
  logic [4:0]  alu_ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] result;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output alu_ctl, a, b, shamt, start,
    input  result, zero, hi, lo, busy, done
  );

  modport slave (
    input  alu_ctl, a, b, shamt, start,
    output result, zero, hi, lo, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational ALU with iterative HI/LO multiply/divide unit
// Optional feature: MIPS_ALU_FAST_MUL_EN selects a single-cycle product for MULT/MULTU.
module alu_muldiv (
  input  logic          clk,
  input  logic          reset,
  alu_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic        setup;
  logic        is_mul;
  logic        is_sgn;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] result_c;
  logic        launch;

  assign launch = bus.start && (bus.alu_ctl == 5'd3  || bus.alu_ctl == 5'd4 ||
                                bus.alu_ctl == 5'd11 || bus.alu_ctl == 5'd12);

  always_comb begin
    result_c = '0;
    case (bus.alu_ctl)
      5'd0:    result_c = bus.a & bus.b;
      5'd1:    result_c = bus.a | bus.b;
      5'd2:    result_c = bus.a + bus.b;
      5'd5:    result_c = bus.a ^ bus.b;
      5'd6:    result_c = bus.a - bus.b;
      5'd7:    result_c = {31'd0, $signed(bus.a) < $signed(bus.b)};
      5'd8:    result_c = {31'd0, bus.a < bus.b};
      5'd9:    result_c = bus.b << bus.shamt;
      5'd10:   result_c = bus.b >> bus.shamt;
      5'd13:   result_c = bus.b << bus.a[4:0];
      5'd14:   result_c = bus.b >> bus.a[4:0];
      5'd15:   result_c = $signed(bus.b) >>> bus.shamt;
      5'd16:   result_c = $signed(bus.b) >>> bus.a[4:0];
      default: result_c = '0;
    endcase
  end

  assign bus.result = result_c;
  assign bus.zero   = (result_c == 32'd0);
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Iterations run on magnitudes; signs are restored when the result is written.
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  assign abs_a = (is_sgn && opa[31]) ? (32'd0 - opa) : opa;
  assign abs_b = (is_sgn && opb[31]) ? (32'd0 - opb) : opb;

  logic [32:0] add_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  always_comb begin
    add_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_a} : 33'd0);
    div_shift = {p_hi, p_lo[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    step_hi   = '0;
    step_lo   = '0;
    if (is_mul) begin
      step_hi = add_sum[32:1];
      step_lo = {add_sum[0], p_lo[31:1]};
    end else if (!div_diff[33]) begin
      step_hi = div_diff[31:0];
      step_lo = {p_lo[30:0], 1'b1};
    end else begin
      step_hi = div_shift[31:0];
      step_lo = {p_lo[30:0], 1'b0};
    end
  end

  logic [63:0] prod_fix;
  logic        mul_neg;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;

  always_comb begin
    mul_neg  = is_sgn && (opa[31] ^ opb[31]);
    q_neg    = is_sgn && (opa[31] ^ opb[31]);
    r_neg    = is_sgn && opa[31];
    prod_fix = mul_neg ? (64'd0 - {step_hi, step_lo}) : {step_hi, step_lo};
    fin_hi   = '0;
    fin_lo   = '0;
    if (is_mul) begin
      fin_hi = prod_fix[63:32];
      fin_lo = prod_fix[31:0];
    end else if (opb == 32'd0) begin
      fin_hi = opa;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = r_neg ? (32'd0 - step_hi) : step_hi;
      fin_lo = q_neg ? (32'd0 - step_lo) : step_lo;
    end
  end

`ifdef MIPS_ALU_FAST_MUL_EN
  // Sign-extended operands give the correct low 64 bits for both signed and unsigned.
  logic [63:0] fast_prod;
  assign fast_prod = {{32{is_sgn & opa[31]}}, opa} * {{32{is_sgn & opb[31]}}, opb};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      setup  <= 1'b0;
      is_mul <= 1'b0;
      is_sgn <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            opa    <= bus.a;
            opb    <= bus.b;
            is_mul <= (bus.alu_ctl == 5'd11) || (bus.alu_ctl == 5'd12);
            is_sgn <= (bus.alu_ctl == 5'd3)  || (bus.alu_ctl == 5'd11);
            setup  <= 1'b1;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (setup) begin
            setup <= 1'b0;
`ifdef MIPS_ALU_FAST_MUL_EN
            if (is_mul) begin
              hi_q   <= fast_prod[63:32];
              lo_q   <= fast_prod[31:0];
              done_q <= 1'b1;
              state  <= DONE;
            end else
`endif
            begin
              mag_a <= abs_a;
              mag_b <= abs_b;
              p_hi  <= '0;
              p_lo  <= is_mul ? abs_b : abs_a;
            end
          end else begin
            p_hi  <= step_hi;
            p_lo  <= step_lo;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              hi_q   <= fin_hi;
              lo_q   <= fin_lo;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv ALU paths and HI/LO unit
module tb_alu_muldiv;

`ifdef MIPS_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if bus ();

  alu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [63:0] val;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_muldiv(input logic [4:0] ctl, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              sq, sr;
    logic [31:0]     uq, ur;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    case (ctl)
      5'd11: return sx * sy;
      5'd12: return ux * uy;
      5'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sq = $signed(x) / $signed(y);
        sr = $signed(x) % $signed(y);
        return {sr, sq};
      end
      5'd4: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = x / y;
        ur = x % y;
        return {ur, uq};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [4:0] ctl, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    bus.alu_ctl = ctl;
    bus.a       = x;
    bus.b       = y;
    bus.start   = 1'b1;
    e.val = model_muldiv(ctl, x, y);
    e.lat = (ctl == 5'd11 || ctl == 5'd12) ? MUL_LAT : DIV_LAT;
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed);
    int   n;
    exp_t e;
    n = elapsed;
    while (!bus.done && n < 100) begin
      tick();
      n++;
      if (!bus.done) check_value("busy_run", {63'd0, bus.busy}, 64'd1);
    end
    check_value("done_seen", {63'd0, bus.done}, 64'd1);
    if (sb.size() == 0) begin
      check_value("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_value("latency", 64'(n), 64'(e.lat));
      check_value("hi", {32'd0, bus.hi}, {32'd0, e.val[63:32]});
      check_value("lo", {32'd0, bus.lo}, {32'd0, e.val[31:0]});
      last_hi = e.val[63:32];
      last_lo = e.val[31:0];
    end
    tick();
    check_value("done_pulse", {63'd0, bus.done}, 64'd0);
    check_value("busy_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$] = '{
    '{5'd2,  32'd7,          32'd5,          5'd0,  32'd12},
    '{5'd6,  32'd5,          32'd5,          5'd0,  32'd0},
    '{5'd15, 32'd0,          32'h8000_0000,  5'd4,  32'hF800_0000},
    '{5'd0,  32'hF0F0_1234,  32'h0FF0_FFFF,  5'd0,  32'h00F0_1234},
    '{5'd1,  32'hF000_0000,  32'h0000_000F,  5'd0,  32'hF000_000F},
    '{5'd5,  32'hFFFF_0000,  32'h0F0F_0F0F,  5'd0,  32'hF0F0_0F0F},
    '{5'd6,  32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF},
    '{5'd2,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0},
    '{5'd7,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1},
    '{5'd8,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0},
    '{5'd9,  32'd0,          32'd1,          5'd31, 32'h8000_0000},
    '{5'd10, 32'd0,          32'h8000_0000,  5'd31, 32'd1},
    '{5'd13, 32'd4,          32'd3,          5'd0,  32'h30},
    '{5'd14, 32'h24,         32'hF0,         5'd0,  32'hF},
    '{5'd16, 32'h1F,         32'h8000_0000,  5'd0,  32'hFFFF_FFFF},
    '{5'd15, 32'd0,          32'h4000_0000,  5'd4,  32'h0400_0000},
    '{5'd3,  32'd5,          32'd5,          5'd0,  32'd0},
    '{5'd31, 32'd1,          32'd2,          5'd0,  32'd0},
    '{5'd17, 32'd9,          32'd3,          5'd0,  32'd0}
  };

  initial begin
    reset       = 1'b1;
    bus.alu_ctl = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.shamt   = '0;
    bus.start   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check_value("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_value("rst_done", {63'd0, bus.done}, 64'd0);
    check_value("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    foreach (vecs[i]) begin
      bus.alu_ctl = vecs[i].ctl;
      bus.a       = vecs[i].x;
      bus.b       = vecs[i].y;
      bus.shamt   = vecs[i].sh;
      #2;
      check_value($sformatf("alu_ctl%0d_result", vecs[i].ctl), {32'd0, bus.result}, {32'd0, vecs[i].exp});
      check_value($sformatf("alu_ctl%0d_zero", vecs[i].ctl), {63'd0, bus.zero}, {63'd0, vecs[i].exp == 32'd0});
    end
    check_value("alu_no_launch", {63'd0, bus.busy}, 64'd0);
    tick();

    launch(5'd11, 32'hFFFF_FFFD, 32'd7);
    wait_done(0);
    launch(5'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(0);
    launch(5'd4, 32'd7, 32'd2);
    wait_done(0);
    launch(5'd4, 32'h10, 32'd0);
    wait_done(0);
    launch(5'd3, 32'h8000_0001, 32'd0);
    wait_done(0);
    launch(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);

    for (int k = 0; k < 8; k++) begin
      logic [4:0]  c;
      logic [31:0] x, y;
      case (k % 4)
        0: c = 5'd11;
        1: c = 5'd12;
        2: c = 5'd3;
        default: c = 5'd4;
      endcase
      x = $urandom;
      y = $urandom;
      if (c == 5'd3 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
      launch(c, x, y);
      wait_done(0);
    end

    // Second start mid-run must not disturb the operation in flight.
    launch(5'd12, 32'd1000, 32'd3000);
    repeat (4) tick();
    check_value("hold_hi", {32'd0, bus.hi}, {32'd0, last_hi});
    check_value("hold_lo", {32'd0, bus.lo}, {32'd0, last_lo});
    bus.alu_ctl = 5'd4;
    bus.a       = 32'd77;
    bus.b       = 32'd5;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(5);

    // Reset mid-multiply aborts; start held with reset must be ignored.
    launch(5'd11, 32'h1234_5678, 32'h8765_4321);
    repeat (9) tick();
    reset       = 1'b1;
    bus.alu_ctl = 5'd12;
    bus.start   = 1'b1;
    tick();
    check_value("abort_busy", {63'd0, bus.busy}, 64'd0);
    check_value("abort_done", {63'd0, bus.done}, 64'd0);
    check_value("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    void'(sb.pop_front());
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check_value("abort_idle", {63'd0, bus.busy}, 64'd0);
    launch(5'd11, 32'hFFFF_FFFD, 32'd7);
    wait_done(0);
    launch(5'd4, 32'd100, 32'd7);
    wait_done(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port alu_ctl  input  5  operation code produced by the ALU control stage.
REQ-004 SHALL have port a  input  32  operand rs.
REQ-005 SHALL have port b  input  32  operand rt or immediate.
REQ-006 SHALL have port shamt  input  5  instruction shift amount.
REQ-007 SHALL have port start  input  1  launch request for codes 3, 4, 11, 12; ignored for other codes.
REQ-008 SHALL have port result  output  32  combinational result for non-mul/div codes.
REQ-009 SHALL have port zero  output  1  high when result == 0.
REQ-010 SHALL have ports hi, lo  output  32 each  registered HI/LO.
REQ-011 SHALL have ports busy, done  output  1 each  mul/div status.

Function
REQ-012 SHALL compute result combinationally, same cycle: 0 AND, 1 OR, 2 add mod 2^32, 5 XOR, 6 a-b mod 2^32, 7 signed a<b (1/0), 8 unsigned a<b.
REQ-013 SHALL shift b: 9 SLL by shamt, 10 SRL by shamt, 15 SRA by shamt, 13 SLLV by a[4:0], 14 SRLV by a[4:0], 16 SRAV by a[4:0].
REQ-014 SHALL drive result = 0 for codes 3, 4, 11, 12 and any undefined code (including 31).
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 SHALL accept start only in IDLE with alu_ctl in {3,4,11,12}; operands and code latched on the accepting edge.
REQ-017 SHALL remain in RUN for exactly 32 cycles using a 5-bit iteration counter, one shift-add (mul) or restoring shift-subtract (div) step per cycle.
REQ-018 SHALL assert busy in RUN and DONE; done high for exactly one cycle in DONE; done first visible 33 edges after the accepting edge.
REQ-019 SHALL update hi/lo only on entry to DONE; hi/lo hold at all other times.
REQ-020 SHALL produce MULT (11) signed / MULTU (12) unsigned 64-bit product: hi = [63:32], lo = [31:0].
REQ-021 SHALL produce DIV (3) signed: lo = quotient truncated toward zero, hi = remainder with dividend's sign; DIVU (4): unsigned quotient/remainder.
REQ-022 SHALL, on divide by zero, run normal latency and return hi = a, lo = 32'hFFFFFFFF.
REQ-023 SHALL ignore start while busy; latched operands unaffected.
REQ-024 SHALL accept a new start in the same cycle the FSM returns to IDLE (cycle after done).

Reset
REQ-025 SHALL, when reset is high at an edge, force IDLE, counter 0, hi = lo = 0, busy = done = 0, regardless of state.
REQ-026 SHALL abort an in-flight operation on reset with no hi/lo update; start coincident with reset ignored.

Configuration
REQ-027 SHALL honour macro MIPS_ALU_FAST_MUL_EN: when defined, codes 11/12 compute a single-cycle 64-bit product, entering DONE on the edge after acceptance (done 1 edge after accept); division unchanged.
REQ-028 SHALL, without MIPS_ALU_FAST_MUL_EN, use the 32-cycle iterative multiplier of REQ-017.

Verification
REQ-029 SHALL cover: ctl=2 a=7 b=5 -> result 12, zero 0; ctl=6 a=5 b=5 -> result 0, zero 1; ctl=15 b=32'h80000000 shamt=4 -> 32'hF8000000.
REQ-030 SHALL cover: ctl=11 a=32'hFFFFFFFD b=7, start 1 cycle -> done 33 edges later, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB (1 edge with MIPS_ALU_FAST_MUL_EN).
REQ-031 SHALL cover: ctl=3 a=32'hFFFFFFF9 b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; ctl=4 a=7 b=2 -> lo=3, hi=1.
REQ-032 SHALL cover: ctl=4 a=32'h10 b=0 -> done after 33 edges, hi=32'h10, lo=32'hFFFFFFFF.
REQ-033 SHALL cover: second start at RUN cycle 5 with different operands -> ignored, first op's result returned.
REQ-034 SHALL cover: reset at RUN cycle 10 of MULT -> next edge busy=0, done=0, hi=lo=0; start next cycle accepted and completes correctly.
